vec_fifo_hs: RTL and testbench

Parametrised vector FIFO with independent write and read chunk widths, valid/ready handshakes on both sides, and per-vector replay. The producer writes a vector in chunks; the consumer reads it in chunks and may rewind to re-read it before releasing it. Storage is freed only when a vector is released. It sits between activation producers and MAC/reservoir consumers that sweep the same input vector several times.

---
 rtl/vec_fifo_pkg.sv | 19 +
 rtl/vec_fifo_ptr.sv | 22 ++
 rtl/vec_fifo_hs.sv | 118 +++++++++++
 tb/tb_vec_fifo_hs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_fifo_pkg.sv
// rtl/vec_fifo_pkg.sv - shared address helpers and configuration checks for vec_fifo_hs
package vec_fifo_pkg;

  function automatic int ptr_w(input int cap);
    return (cap <= 2) ? 1 : $clog2(cap);
  endfunction

  // Single conditional subtract: callers keep ptr < cap and inc <= cap.
  function automatic int wrap_add(input int ptr, input int inc, input int cap);
    int s;
    s = ptr + inc;
    return (s >= cap) ? s - cap : s;
  endfunction

  function automatic bit divisible(input int a, input int b);
    return (b > 0) && (a > 0) && ((a % b) == 0);
  endfunction

endpackage

// File: rtl/vec_fifo_ptr.sv
// rtl/vec_fifo_ptr.sv - modulo-Cap pointer register advancing by a per-cycle increment
module vec_fifo_ptr
  import vec_fifo_pkg::*;
#(
  parameter int Cap = 16,
  parameter int W   = ptr_w(Cap)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W:0]   inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc != '0) begin
      ptr <= W'(wrap_add(int'(ptr), int'(inc), Cap));
    end
  end

endmodule

// File: rtl/vec_fifo_hs.sv
// rtl/vec_fifo_hs.sv - vector FIFO with chunked write/read, replay and release
// Optional sticky protocol error flag: VEC_FIFO_ERR_EN.
module vec_fifo_hs
  import vec_fifo_pkg::*;
#(
  parameter int VecElements      = 8,
  parameter int ElementsPerWrite = 2,
  parameter int ElementsPerRead  = 4,
  parameter int NBits            = 8,
  parameter int Depth            = 2
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         wr_valid,
  output logic                                         wr_ready,
  input  logic [ElementsPerWrite-1:0][NBits-1:0]       wr_data,
  output logic                                         rd_valid,
  input  logic                                         rd_ready,
  output logic [ElementsPerRead-1:0][NBits-1:0]        rd_data,
  output logic                                         rd_last,
  input  logic                                         rd_rewind,
  output logic [$clog2(Depth+1)-1:0]                   vec_count,
  output logic                                         empty,
  output logic                                         err
);

  localparam int Cap = Depth * VecElements;
  localparam int AW  = ptr_w(Cap);
  localparam int OW  = ptr_w(VecElements);
  localparam int UW  = $clog2(Cap + 1);
  localparam int VW  = $clog2(Depth + 1);
  localparam bit CfgOk = divisible(VecElements, ElementsPerWrite) &&
                         divisible(VecElements, ElementsPerRead) && (Depth > 0);

  if (!CfgOk) begin : g_bad_cfg
    $error("vec_fifo_hs: VecElements must be a multiple of both chunk widths");
  end

  logic [NBits-1:0] mem [Cap];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_base;
  logic [OW-1:0]    rd_off;
  logic [UW-1:0]    used;
  logic             wr_fire;
  logic             rd_fire;
  logic             release_vec;

  // used counts from rd_base, so the unread tail beyond rd_off is used - rd_off.
  assign wr_ready    = (UW'(Cap) - used) >= UW'(ElementsPerWrite);
  assign rd_valid    = (used - UW'(rd_off)) >= UW'(ElementsPerRead);
  assign rd_last     = (rd_off == OW'(VecElements - ElementsPerRead));
  assign empty       = (used == '0);
  assign vec_count   = VW'(used / UW'(VecElements));
  assign wr_fire     = wr_valid && wr_ready;
  assign rd_fire     = rd_valid && rd_ready && !rd_rewind;
  assign release_vec = rd_fire && rd_last;

  vec_fifo_ptr #(.Cap(Cap), .W(AW)) u_wr_ptr (
    .clk (clk_in),
    .rst (rst_in),
    .inc (wr_fire ? (AW+1)'(ElementsPerWrite) : '0),
    .ptr (wr_ptr)
  );

  vec_fifo_ptr #(.Cap(Cap), .W(AW)) u_rd_base (
    .clk (clk_in),
    .rst (rst_in),
    .inc (release_vec ? (AW+1)'(VecElements) : '0),
    .ptr (rd_base)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      used   <= '0;
      rd_off <= '0;
    end else begin
      used <= used + (wr_fire ? UW'(ElementsPerWrite) : '0)
                   - (release_vec ? UW'(VecElements) : '0);
      if (rd_rewind) begin
        rd_off <= '0;
      end else if (rd_fire) begin
        rd_off <= rd_last ? '0 : rd_off + OW'(ElementsPerRead);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_fire) begin
      for (int i = 0; i < ElementsPerWrite; i++) begin
        mem[AW'(wrap_add(int'(wr_ptr), i, Cap))] <= wr_data[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < ElementsPerRead; i++) begin
      rd_data[i] = mem[AW'(wrap_add(int'(rd_base), int'(rd_off) + i, Cap))];
    end
  end

`ifdef VEC_FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
    end else if ((wr_valid && !wr_ready) || (rd_ready && !rd_valid && !rd_rewind)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_fifo_hs.sv
// tb/tb_vec_fifo_hs.sv - directed self-checking bench for vec_fifo_hs
module tb_vec_fifo_hs;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [1:0][7:0] wr_data = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [3:0][7:0] rd_data;
  logic            rd_last;
  logic            rd_rewind = 1'b0;
  logic [1:0]      vec_count;
  logic            empty;
  logic            err;

  int checks = 0;
  int errors = 0;

  vec_fifo_hs dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_rewind (rd_rewind),
    .vec_count (vec_count),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    wr_valid = 0; rd_ready = 0; rd_rewind = 0;
    rst = 1;
    tick; tick;
    rst = 0;
    tick;
  endtask

  task automatic write_chunk(input logic [7:0] e0, input logic [7:0] e1);
    wr_data[0] = e0;
    wr_data[1] = e1;
    wr_valid = 1;
    tick;
    wr_valid = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b want 0", rd_last); end
    checks++; if (vec_count !== 2'd0) begin errors++; $display("FAIL reset_vec_count got %0d want 0", vec_count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_basic;
    do_reset;
    for (int c = 0; c < 4; c++) write_chunk(8'(2*c+1), 8'(2*c+2));
    checks++; if (vec_count !== 2'd1) begin errors++; $display("FAIL basic_vec_count got %0d want 1", vec_count); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid got %b want 1", rd_valid); end
    checks++; if (rd_data !== 32'h04030201) begin errors++; $display("FAIL basic_chunk0 got %h want 04030201", rd_data); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL basic_last0 got %b want 0", rd_last); end
    rd_ready = 1;
    tick;
    checks++; if (rd_data !== 32'h08070605) begin errors++; $display("FAIL basic_chunk1 got %h want 08070605", rd_data); end
    checks++; if (rd_last !== 1'b1) begin errors++; $display("FAIL basic_last1 got %b want 1", rd_last); end
    tick;
    rd_ready = 0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", empty); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL basic_wr_ready got %b want 1", wr_ready); end
    checks++; if (vec_count !== 2'd0) begin errors++; $display("FAIL basic_vec_count_after got %0d want 0", vec_count); end
  endtask

  task automatic test_full;
    do_reset;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before8 got %b want 1", wr_ready); end
      end
      write_chunk(8'(8'h10 + 2*c), 8'(8'h11 + 2*c));
    end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b want 0", wr_ready); end
    checks++; if (vec_count !== 2'd2) begin errors++; $display("FAIL full_vec_count got %0d want 2", vec_count); end
    checks++; if (rd_data !== 32'h13121110) begin errors++; $display("FAIL full_a_chunk0 got %h want 13121110", rd_data); end
    rd_ready = 1;
    tick;
    wr_data[0] = 8'hAA; wr_data[1] = 8'hBB; wr_valid = 1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at_release got %b want 0", wr_ready); end
    tick;
    wr_valid = 0;
    rd_ready = 0;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_release got %b want 1", wr_ready); end
    checks++; if (vec_count !== 2'd1) begin errors++; $display("FAIL full_vec_count_after got %0d want 1", vec_count); end
    checks++; if (rd_data !== 32'h1B1A1918) begin errors++; $display("FAIL full_b_chunk0 got %h want 1B1A1918", rd_data); end
    rd_ready = 1;
    tick;
    checks++; if (rd_data !== 32'h1F1E1D1C) begin errors++; $display("FAIL full_b_chunk1 got %h want 1F1E1D1C", rd_data); end
    tick;
    rd_ready = 0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_refused_write_empty got %b want 1", empty); end
  endtask

  task automatic test_rewind;
    do_reset;
    for (int c = 0; c < 4; c++) write_chunk(8'(8'h20 + 2*c), 8'(8'h21 + 2*c));
    rd_ready = 1;
    tick;
    checks++; if (rd_data !== 32'h27262524) begin errors++; $display("FAIL rewind_chunk1 got %h want 27262524", rd_data); end
    rd_rewind = 1;
    tick;
    rd_rewind = 0;
    checks++; if (rd_data !== 32'h23222120) begin errors++; $display("FAIL rewind_back_to0 got %h want 23222120", rd_data); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL rewind_last0 got %b want 0", rd_last); end
    tick;
    checks++; if (rd_last !== 1'b1) begin errors++; $display("FAIL rewind_last1 got %b want 1", rd_last); end
    rd_rewind = 1;
    tick;
    rd_rewind = 0;
    checks++; if (vec_count !== 2'd1) begin errors++; $display("FAIL rewind_no_release got %0d want 1", vec_count); end
    checks++; if (rd_data !== 32'h23222120) begin errors++; $display("FAIL rewind_replay0 got %h want 23222120", rd_data); end
    tick; tick;
    rd_ready = 0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rewind_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    fork
      begin : producer
        int idx = 0;
        int cyc = 0;
        logic fire;
        while (idx < 80) begin
          if (cyc >= 3000) begin
            errors++; checks++;
            $display("FAIL b2b_producer_timeout got %0d chunks want 80", idx);
            break;
          end
          wr_valid = ($urandom_range(3) != 0);
          wr_data[0] = 8'(2*idx) ^ 8'hA5;
          wr_data[1] = 8'(2*idx + 1) ^ 8'hA5;
          fire = wr_valid && wr_ready;
          tick;
          if (fire) idx++;
          cyc++;
        end
        wr_valid = 0;
      end
      begin : consumer
        int ridx = 0;
        int cyc = 0;
        logic [31:0] exp;
        while (ridx < 160) begin
          if (cyc >= 3000) begin
            errors++; checks++;
            $display("FAIL b2b_consumer_timeout got %0d elements want 160", ridx);
            break;
          end
          rd_ready = ($urandom_range(3) != 0);
          if (rd_valid && rd_ready) begin
            for (int j = 0; j < 4; j++) exp[8*j +: 8] = 8'(ridx + j) ^ 8'hA5;
            checks++;
            if (rd_data !== exp || rd_last !== ((ridx % 8) == 4)) begin
              errors++;
              $display("FAIL b2b_chunk at %0d got %h last %b want %h last %b",
                       ridx, rd_data, rd_last, exp, ((ridx % 8) == 4));
            end
            tick;
            ridx += 4;
          end else begin
            tick;
          end
          cyc++;
        end
        rd_ready = 0;
      end
    join
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_err;
    do_reset;
    for (int c = 0; c < 8; c++) write_chunk(8'(c), 8'(c));
    wr_valid = 1;
    tick;
    wr_valid = 0;
`ifdef VEC_FIFO_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    tick; tick;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied got %b want 0", err); end
    tick; tick;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied_later got %b want 0", err); end
`endif
    do_reset;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
  endtask

  task automatic test_async_reset;
    do_reset;
    for (int c = 0; c < 3; c++) write_chunk(8'(c), 8'(c));
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", rd_valid); end
    rd_ready = 1;
    wr_valid = 1;
    #3;
    rst = 1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd_valid got %b want 0", rd_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b want 1", empty); end
    checks++; if (vec_count !== 2'd0) begin errors++; $display("FAIL arst_vec_count got %0d want 0", vec_count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL arst_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL arst_rd_last got %b want 0", rd_last); end
    rd_ready = 0;
    wr_valid = 0;
    #2;
    rst = 0;
    tick;
    for (int c = 0; c < 4; c++) write_chunk(8'(8'h40 + 2*c), 8'(8'h41 + 2*c));
    checks++; if (vec_count !== 2'd1) begin errors++; $display("FAIL arst_restart_count got %0d want 1", vec_count); end
    checks++; if (rd_data !== 32'h43424140) begin errors++; $display("FAIL arst_restart_data got %h want 43424140", rd_data); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_rewind;
    test_back_to_back;
    test_err;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
